// File: rtl/addmul_pkg.sv
// Shared definitions for the calculator arithmetic back-end.
//   ADDMUL_WIDTH  : operand/result width (two's complement)
//   mul_state_t   : multiplier FSM state encoding
//   addmul_word_t : signed operand/result word
package addmul_pkg;

    localparam int ADDMUL_WIDTH = 16;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

    typedef logic signed [ADDMUL_WIDTH-1:0] addmul_word_t;

endpackage

// File: rtl/addition_multiply_if.sv
// Bus between the calculator control FSM (master) and the arithmetic
// back-end (slave).
//   add_in1/add_in2/add_sub/add_start  : adder request
//   add_out/add_finish                 : adder response
//   mul_in1/mul_in2/mul_start          : multiplier request
//   mul_out/mul_finish/mul_busy        : multiplier response
//   mul_state                          : multiplier FSM state (debug observation)
//   add_ovf/mul_ovf                    : overflow flags, only when
//                                        ADDMUL_OVERFLOW_EN is defined
// Handshake: a start is a single-cycle request sampled at the rising edge.
// The matching finish is a one-cycle pulse during which the result is valid;
// the result then holds until the next accepted start. The adder accepts
// every start; the multiplier drops any start seen while mul_busy is high.
interface addition_multiply_if
    import addmul_pkg::*;
#(
    parameter int WIDTH = ADDMUL_WIDTH
);
    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic             add_sub;
    logic             add_start;
    logic [WIDTH-1:0] add_out;
    logic             add_finish;
    logic [WIDTH-1:0] mul_in1;
    logic [WIDTH-1:0] mul_in2;
    logic             mul_start;
    logic [WIDTH-1:0] mul_out;
    logic             mul_finish;
    logic             mul_busy;
    mul_state_t       mul_state;
`ifdef ADDMUL_OVERFLOW_EN
    logic             add_ovf;
    logic             mul_ovf;

    modport master (
        output add_in1, add_in2, add_sub, add_start,
        output mul_in1, mul_in2, mul_start,
        input  add_out, add_finish, add_ovf,
        input  mul_out, mul_finish, mul_busy, mul_ovf, mul_state
    );

    modport slave (
        input  add_in1, add_in2, add_sub, add_start,
        input  mul_in1, mul_in2, mul_start,
        output add_out, add_finish, add_ovf,
        output mul_out, mul_finish, mul_busy, mul_ovf, mul_state
    );
`else
    modport master (
        output add_in1, add_in2, add_sub, add_start,
        output mul_in1, mul_in2, mul_start,
        input  add_out, add_finish,
        input  mul_out, mul_finish, mul_busy, mul_state
    );

    modport slave (
        input  add_in1, add_in2, add_sub, add_start,
        input  mul_in1, mul_in2, mul_start,
        output add_out, add_finish,
        output mul_out, mul_finish, mul_busy, mul_state
    );
`endif

endinterface

// File: rtl/seq_multiplier.sv
// Sequential signed shift-add multiplier.
// Works on operand magnitudes, then applies the product sign at the end.
// Latency: finish pulses WIDTH+1 edges after the accepting edge.
//   clk, nRST : clock (rising edge), asynchronous active-low reset
//   in1, in2  : multiplicand, multiplier (two's complement)
//   start     : request; dropped while busy
//   product   : low WIDTH bits of the signed product, held until next start
//   finish    : one-cycle pulse, product valid
//   busy      : from the accepting edge through the finish cycle
//   ovf       : product does not fit in WIDTH bits (ADDMUL_OVERFLOW_EN only)
//   state     : FSM state for observation
// ADDMUL_OVERFLOW_EN widens the accumulator to 2*WIDTH to detect overflow;
// the wrapped product is the same either way.
module seq_multiplier
    import addmul_pkg::*;
#(
    parameter int WIDTH = ADDMUL_WIDTH
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             start,
    output logic [WIDTH-1:0] product,
    output logic             finish,
    output logic             busy,
`ifdef ADDMUL_OVERFLOW_EN
    output logic             ovf,
`endif
    output mul_state_t       state
);
`ifdef ADDMUL_OVERFLOW_EN
    localparam int ACC_W = 2 * WIDTH;
    // Smallest magnitude that no longer fits as a positive WIDTH-bit value.
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (WIDTH - 1);
`else
    localparam int ACC_W = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_t       state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic             accept;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] acc_lo;

    // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    assign mag1   = in1[WIDTH-1] ? -in1 : in1;
    assign mag2   = in2[WIDTH-1] ? -in2 : in2;
    assign acc_lo = acc[WIDTH-1:0];

    // The finish cycle is IDLE but still counts as busy, so a start there
    // is dropped as well.
    assign busy   = (state != MUL_IDLE) || finish;
    assign accept = start && !busy;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= MUL_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (accept) state_next = MUL_RUN;
            MUL_RUN:  if (cnt == LAST_STEP) state_next = MUL_DONE;
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            product <= '0;
            finish  <= 1'b0;
`ifdef ADDMUL_OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            finish <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (accept) begin
                        mcand  <= ACC_W'(mag1);
                        mplier <= mag2;
                        sign   <= in1[WIDTH-1] ^ in2[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                MUL_DONE: begin
                    product <= sign ? -acc_lo : acc_lo;
                    finish  <= 1'b1;
`ifdef ADDMUL_OVERFLOW_EN
                    // A negative product may reach magnitude 2^(WIDTH-1);
                    // a positive one must stay below it.
                    ovf     <= sign ? (acc > HALF) : (acc >= HALF);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/addition_multiply.sv
// Arithmetic back-end of the 16-bit signed calculator: a single-cycle
// adder/subtractor (inline) and a sequential shift-add multiplier
// (seq_multiplier), each with its own start/finish handshake.
//   clk, nRST : clock (rising edge), asynchronous active-low reset
//   bus       : addition_multiply_if slave modport carrying
//               add_in1/add_in2/add_sub/add_start -> add_out/add_finish
//               mul_in1/mul_in2/mul_start -> mul_out/mul_finish/mul_busy
//               plus mul_state for observation
// ADDMUL_OVERFLOW_EN adds add_ovf and mul_ovf to the bus, updated together
// with the matching finish.
module addition_multiply
    import addmul_pkg::*;
#(
    parameter int WIDTH = ADDMUL_WIDTH
) (
    input logic                  clk,
    input logic                  nRST,
    addition_multiply_if.slave   bus
);
    logic [WIDTH-1:0] add_sum;

    assign add_sum = bus.add_sub ? (bus.add_in1 - bus.add_in2)
                                 : (bus.add_in1 + bus.add_in2);

`ifdef ADDMUL_OVERFLOW_EN
    logic b_eff_msb;
    logic add_ovf_next;

    // Subtraction overflows like addition of the negated operand.
    assign b_eff_msb    = bus.add_sub ? ~bus.add_in2[WIDTH-1] : bus.add_in2[WIDTH-1];
    assign add_ovf_next = (bus.add_in1[WIDTH-1] == b_eff_msb) &&
                          (add_sum[WIDTH-1] != bus.add_in1[WIDTH-1]);
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bus.add_out    <= '0;
            bus.add_finish <= 1'b0;
`ifdef ADDMUL_OVERFLOW_EN
            bus.add_ovf    <= 1'b0;
`endif
        end else begin
            bus.add_finish <= bus.add_start;
            if (bus.add_start) begin
                bus.add_out <= add_sum;
`ifdef ADDMUL_OVERFLOW_EN
                bus.add_ovf <= add_ovf_next;
`endif
            end
        end
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .nRST    (nRST),
        .in1     (bus.mul_in1),
        .in2     (bus.mul_in2),
        .start   (bus.mul_start),
        .product (bus.mul_out),
        .finish  (bus.mul_finish),
        .busy    (bus.mul_busy),
`ifdef ADDMUL_OVERFLOW_EN
        .ovf     (bus.mul_ovf),
`endif
        .state   (bus.mul_state)
    );

endmodule

// File: tb/tb_addition_multiply.sv
// Bench for addition_multiply: directed vectors with hand-computed results.
// Drivers push expected value, expected finish cycle and expected overflow
// flag into queues; a monitor pops and compares on every finish pulse.
module tb_addition_multiply;
    import addmul_pkg::*;

    localparam int W = ADDMUL_WIDTH;
    localparam int MUL_LAT = W + 1;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    addition_multiply_if #(.WIDTH(W)) bus ();

    addition_multiply #(.WIDTH(W)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] add_exp_q[$];
    int           add_cyc_q[$];
    logic         add_ovf_q[$];
    logic [W-1:0] mul_exp_q[$];
    int           mul_cyc_q[$];
    logic         mul_ovf_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- clock/reset helpers and drivers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bus.add_in1   = a;
        bus.add_in2   = b;
        bus.add_sub   = sub;
        bus.add_start = 1'b1;
    endtask

    task automatic set_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.mul_in1   = a;
        bus.mul_in2   = b;
        bus.mul_start = 1'b1;
    endtask

    // Apply pending starts at the next edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.add_start = 1'b0;
        bus.mul_start = 1'b0;
    endtask

    // Called just after the sampling edge: finish is visible in this cycle.
    task automatic expect_add(input logic [W-1:0] v, input logic ovf);
        add_exp_q.push_back(v);
        add_cyc_q.push_back(cyc);
        add_ovf_q.push_back(ovf);
    endtask

    task automatic expect_mul(input logic [W-1:0] v, input logic ovf);
        mul_exp_q.push_back(v);
        mul_cyc_q.push_back(cyc + MUL_LAT);
        mul_ovf_q.push_back(ovf);
    endtask

    task automatic wait_mul_idle();
        int n;
        n = 0;
        while (bus.mul_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("mul_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] v, input logic ovf);
        set_mul(a, b);
        tick();
        expect_mul(v, ovf);
        wait_mul_idle();
        wait_cycles(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           c;
        logic         o;
        if (nRST) begin
            if (bus.add_finish) begin
                if (add_exp_q.size() == 0) begin
                    check("add_unexpected_finish", 32'd1, 32'd0);
                end else begin
                    e = add_exp_q.pop_front();
                    c = add_cyc_q.pop_front();
                    o = add_ovf_q.pop_front();
                    check("add_out", 32'(bus.add_out), 32'(e));
                    check("add_finish_cycle", cyc, c);
`ifdef ADDMUL_OVERFLOW_EN
                    check("add_ovf", 32'(bus.add_ovf), 32'(o));
`endif
                end
            end
            if (bus.mul_finish) begin
                if (mul_exp_q.size() == 0) begin
                    check("mul_unexpected_finish", 32'd1, 32'd0);
                end else begin
                    e = mul_exp_q.pop_front();
                    c = mul_cyc_q.pop_front();
                    o = mul_ovf_q.pop_front();
                    check("mul_out", 32'(bus.mul_out), 32'(e));
                    check("mul_finish_cycle", cyc, c);
`ifdef ADDMUL_OVERFLOW_EN
                    check("mul_ovf", 32'(bus.mul_ovf), 32'(o));
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        nRST          = 1'b0;
        bus.add_in1   = '0;
        bus.add_in2   = '0;
        bus.add_sub   = 1'b0;
        bus.add_start = 1'b0;
        bus.mul_in1   = '0;
        bus.mul_in2   = '0;
        bus.mul_start = 1'b0;

        wait_cycles(3);
        check("rst_add_out", 32'(bus.add_out), 32'h0);
        check("rst_add_finish", 32'(bus.add_finish), 32'h0);
        check("rst_mul_out", 32'(bus.mul_out), 32'h0);
        check("rst_mul_finish", 32'(bus.mul_finish), 32'h0);
        check("rst_mul_busy", 32'(bus.mul_busy), 32'h0);
        check("rst_mul_state", 32'(bus.mul_state), 32'(MUL_IDLE));
        nRST = 1'b1;
        wait_cycles(2);

        // Adder vectors: value, overflow.
        set_add(16'h0007, 16'h0005, 1'b0); tick(); expect_add(16'h000C, 1'b0); // 7+5
        @(negedge clk); @(negedge clk);
        check("add_finish_one_cycle", 32'(bus.add_finish), 32'h0);
        set_add(16'h0003, 16'h000A, 1'b1); tick(); expect_add(16'hFFF9, 1'b0); // 3-10
        set_add(16'h7FFF, 16'h0001, 1'b0); tick(); expect_add(16'h8000, 1'b1); // 32767+1
        set_add(16'h8000, 16'h0001, 1'b1); tick(); expect_add(16'h7FFF, 1'b1); // -32768-1
        set_add(16'hFFFF, 16'hFFFF, 1'b0); tick(); expect_add(16'hFFFE, 1'b0); // -1+-1
        // Held start: finish every cycle.
        set_add(16'h0002, 16'h0002, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            expect_add(16'h0004, 1'b0);
        end
        tick(); expect_add(16'h0004, 1'b0);
        wait_cycles(2);

        // 12*10 with busy profile: high from the start edge through finish.
        set_mul(16'h000C, 16'h000A);
        tick();
        expect_mul(16'h0078, 1'b0);
        for (int i = 0; i < MUL_LAT + 1; i++) begin
            @(negedge clk);
            check("mul_busy_high", 32'(bus.mul_busy), 32'h1);
        end
        @(negedge clk);
        check("mul_busy_low", 32'(bus.mul_busy), 32'h0);
        wait_cycles(1);

        run_mul(16'hFFFD, 16'h0007, 16'hFFEB, 1'b0); // -3*7 = -21
        run_mul(16'hFFFC, 16'hFFFB, 16'h0014, 1'b0); // -4*-5 = 20
        run_mul(16'd300,  16'd300,  16'h5F90, 1'b1); // 90000 wraps
        run_mul(16'h8000, 16'h0001, 16'h8000, 1'b0); // -32768*1 fits
        run_mul(16'h8000, 16'hFFFF, 16'h8000, 1'b1); // -32768*-1 overflows

        // Simultaneous starts, then a dropped start during RUN.
        set_add(16'h0010, 16'h0001, 1'b1);
        set_mul(16'h0005, 16'h0006);
        tick();
        expect_add(16'h000F, 1'b0);
        expect_mul(16'h001E, 1'b0);
        wait_cycles(4);
        set_mul(16'h0009, 16'h0009); tick();
        set_add(16'h0064, 16'h0032, 1'b0); tick(); expect_add(16'h0096, 1'b0);
        wait_mul_idle();
        wait_cycles(1);

        // Starts in the DONE cycle and in the finish cycle are both dropped.
        set_mul(16'h0002, 16'h0003);
        tick();
        expect_mul(16'h0006, 1'b0);
        wait_cycles(W);
        set_mul(16'h0009, 16'h0009); tick();
        set_mul(16'h0009, 16'h0009); tick();
        wait_cycles(3);
        check("mul_idle_after_drop", 32'(bus.mul_busy), 32'h0);

        // Reset in the middle of a multiply.
        set_mul(16'd100, 16'd3);
        tick();
        wait_cycles(7);
        nRST = 1'b0;
        #1;
        check("abort_mul_out", 32'(bus.mul_out), 32'h0);
        check("abort_mul_busy", 32'(bus.mul_busy), 32'h0);
        check("abort_mul_finish", 32'(bus.mul_finish), 32'h0);
        check("abort_add_out", 32'(bus.add_out), 32'h0);
        check("abort_mul_state", 32'(bus.mul_state), 32'(MUL_IDLE));
        wait_cycles(2);
        nRST = 1'b1;
        wait_cycles(25);
        run_mul(16'h0006, 16'h0007, 16'h002A, 1'b0); // 6*7

        wait_cycles(3);
        check("add_queue_empty", add_exp_q.size(), 32'd0);
        check("mul_queue_empty", mul_exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
